ssd_scan_ctrl: RTL
==================

Name: ssd_scan_ctrl

Overview:
Time-multiplexing controller for the board's 4-digit, common-anode seven-segment display.
- Holds a 16-bit BCD word (four nibbles) and scans one digit at a time through an internal BCD-to-segment decoder.
- Drives the active-low digit selects and the active-low segment lines.
- Sits between the application logic that produces display values and the display pins.
- New values are double-buffered and applied only at a frame boundary, so a frame never shows a mix of old and new digits.

Parameters:
SCAN_DIV, 50000, clock cycles per digit slot; must be greater than BLANK_CYCLES+1.
BLANK_CYCLES, 16, cycles at the start of each slot with all digits off (ghosting guard); must be at least 1.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset; asynchronous, active-high.
load  in  1  single-cycle strobe; captures value, dp_in and blank_lz.
value  in  16  four BCD nibbles; [15:12] is the leftmost digit.
dp_in  in  4  decimal-point enables, active-high; bit 3 is the leftmost digit.
blank_lz  in  1  leading-zero suppression enable.
pending  out  1  a loaded value is waiting for the next frame boundary.
sel  out  4  digit selects, active-low; 0111 selects the leftmost digit.
ssd  out  7  segments gfedcba, active-low.
dp  out  1  decimal point, active-low.
frame_tick  out  1  one-cycle pulse at each frame boundary.

Behaviour:
Reset (asynchronous, active-high):
- sel=1111, ssd=1111111, dp=1, frame_tick=0, pending=0.
- Display and pending registers clear to 0; blank_lz register clears to 0.
- digit index=0, state=BLANK, slot counter=0.
- A reset asserted mid-frame abandons the frame and the pending value.

Scan timing:
- Slot counter runs 0..SCAN_DIV-1 and wraps.
- At the wrap, the digit index advances 0→1→2→3→0.
- Digit index 0 maps to sel=0111, 1 to 1011, 2 to 1101, 3 to 1110.
- Frame period is 4*SCAN_DIV cycles.

State machine:
- BLANK while counter < BLANK_CYCLES: sel=1111, ssd=1111111, dp=1.
- DRIVE for the rest of the slot: sel selects the current digit; ssd=decode(nibble); dp=~dp bit for that digit.
- Outputs are registered: pins reflect the counter, state and digit index of the previous cycle (one-cycle latency).

Frame boundary:
- Defined as the cycle in which the counter wraps while digit index=3.
- On that cycle: frame_tick=1. If pending=1, the display registers take the pending registers and pending clears.

Load handshake (always accepted, never stalls):
- load with pending=0: capture into the pending registers; pending=1 on the next cycle.
- load with pending=1: overwrite the pending registers (latest wins); pending stays 1.
- load on the frame-boundary cycle: the display takes the previously pending contents, if any. The new load becomes pending and is applied at the following boundary.

Leading-zero suppression (evaluated on the display registers):
- Applies when the registered blank_lz=1.
- Digit k (k=0..2) is blanked if its nibble and all more-significant nibbles are 0.
- Digit 3 is never blanked.
- A blanked digit gives ssd=1111111 and dp=1, but sel is still driven.

Decode (gfedcba, active-low):
- 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001
- 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000
- 10..15: 1111111 (blank).

Counter width: clog2(SCAN_DIV).

Decomposition:
Shared package ssd_pkg:
- segment-code constants SEG_0..SEG_9 and SEG_BLANK=7'b1111111
- sel constant SEL_NONE=4'b1111
- state encoding BLANK=0, DRIVE=1
Sub-module bcd_to_seg: combinational 4-bit to 7-bit decoder implementing the table above, instantiated once on the muxed nibble.

Test Plan:
All scenarios use SCAN_DIV=8 and BLANK_CYCLES=2.
1. After reset, no load -> sel 1111 in BLANK cycles, each digit in DRIVE shows 1000000; pending=0; frame_tick pulses every 32 cycles.
2. load value=16'h1234, dp_in=0010 -> unchanged until the boundary. In the next frame: sel 0111 shows 1111001, 1011 shows 0100100, 1101 shows 0110000 with dp=0, 1110 shows 0011001. pending falls at the boundary.
3. load 16'h1111 then 16'h9876 within one frame -> the next frame shows 0010000, 0000000, 1111000, 0000010; 16'h1111 is never displayed.
4. blank_lz=1, value=16'h0050 -> digits 0 and 1 show 1111111, digit 2 shows 0010010, digit 3 shows 1000000. value=16'h0000 -> only digit 3 is lit, showing 1000000.
5. value=16'hA5F3 -> digits 0 and 2 blank, digit 1 shows 0010010, digit 3 shows 0110000.
6. Assert rst mid-DRIVE of digit 2 with a value pending -> outputs immediately return to reset values. After release: pending=0, scanning restarts at digit 0 / BLANK, and all digits show 0.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared constants, types and helpers for the seven-segment scan controller.
package ssd_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] SEL_NONE  = 4'b1111;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  // One displayable frame: four BCD nibbles, dp enables, leading-zero mode.
  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blank_lz;
  } disp_word_t;

  // Active-low select for digit index 0..3 (0 is the leftmost digit).
  function automatic logic [3:0] sel_decode(input logic [1:0] idx);
    return ~(4'b1000 >> idx);
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low gfedcba segment decoder; 10..15 blank.
module bcd_to_seg
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit common-anode scan controller with frame-aligned double buffering
// and optional leading-zero suppression.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic        pending,
  output logic [3:0]  sel,
  output logic [6:0]  ssd,
  output logic        dp,
  output logic        frame_tick
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       digit, digit_next;
  state_t           state, state_next;
  logic             wrap, boundary;

  disp_word_t       disp_q, pend_q;
  logic [3:0]       nibble;
  logic [6:0]       seg_dec;
  logic [2:0]       lead_zero;
  logic             lz_blank, dp_bit;

  logic [3:0]       sel_next;
  logic [6:0]       ssd_next;
  logic             dp_next;

  // Current-digit nibble, dp enable and leading-zero blanking from display regs.
  always_comb begin
    nibble       = disp_q.value[3:0];
    dp_bit       = disp_q.dp[0];
    lz_blank     = 1'b0;
    lead_zero[0] = (disp_q.value[15:12] == 4'd0);
    lead_zero[1] = lead_zero[0] && (disp_q.value[11:8] == 4'd0);
    lead_zero[2] = lead_zero[1] && (disp_q.value[7:4] == 4'd0);
    case (digit)
      2'd0: begin nibble = disp_q.value[15:12]; dp_bit = disp_q.dp[3]; lz_blank = lead_zero[0]; end
      2'd1: begin nibble = disp_q.value[11:8];  dp_bit = disp_q.dp[2]; lz_blank = lead_zero[1]; end
      2'd2: begin nibble = disp_q.value[7:4];   dp_bit = disp_q.dp[1]; lz_blank = lead_zero[2]; end
      default: begin nibble = disp_q.value[3:0]; dp_bit = disp_q.dp[0]; lz_blank = 1'b0; end
    endcase
    lz_blank = lz_blank && disp_q.blank_lz;
  end

  bcd_to_seg u_dec (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  // Scan sequencing and next pin values.
  always_comb begin
    cnt_next   = cnt + CNT_W'(1);
    digit_next = digit;
    wrap       = (cnt == CNT_LAST);
    boundary   = 1'b0;
    sel_next   = SEL_NONE;
    ssd_next   = SEG_BLANK;
    dp_next    = 1'b1;

    if (wrap) begin
      cnt_next   = '0;
      digit_next = digit + 2'd1;
      boundary   = (digit == 2'd3);
    end
    state_next = (cnt_next < BLANK_END) ? BLANK : DRIVE;

    if (state == DRIVE) begin
      sel_next = sel_decode(digit);
      if (!lz_blank) begin
        ssd_next = seg_dec;
        dp_next  = ~dp_bit;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      digit      <= 2'd0;
      state      <= BLANK;
      sel        <= SEL_NONE;
      ssd        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      digit      <= digit_next;
      state      <= state_next;
      sel        <= sel_next;
      ssd        <= ssd_next;
      dp         <= dp_next;
      frame_tick <= boundary;
    end
  end

  // Double buffer: a boundary promotes the pending word, then a same-cycle load refills it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q  <= '0;
      pend_q  <= '0;
      pending <= 1'b0;
    end else begin
      if (boundary && pending) begin
        disp_q  <= pend_q;
        pending <= 1'b0;
      end
      if (load) begin
        pend_q  <= '{value: value, dp: dp_in, blank_lz: blank_lz};
        pending <= 1'b1;
      end
    end
  end

endmodule
